// File: rtl/lpa_result_collector.sv
// Drain end of the linear processing array: buffers skewed per-column lanes and re-serialises them row-major.
// Optional feature macro LPA_COLLECT_ROW_COUNT_EN adds a row_count output of fully emitted rows.
module lpa_result_collector #(
  parameter  int unsigned PE_NUMBER_I = 4,
  parameter  int unsigned DATA_WIDTH  = 16,
  parameter  int unsigned FIFO_DEPTH  = 4,
  parameter  int unsigned ID_ENABLE   = 0,
  parameter  int unsigned DEST_ENABLE = 0,
  parameter  int unsigned USER_ENABLE = 0,
  localparam int unsigned ID_WIDTH    = (ID_ENABLE   != 0) ? 8 : 1,
  localparam int unsigned DEST_WIDTH  = (DEST_ENABLE != 0) ? 8 : 1,
  localparam int unsigned USER_WIDTH  = (USER_ENABLE != 0) ? 8 : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PE_NUMBER_I*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PE_NUMBER_I-1:0]            s_axis_tvalid,
  output logic [PE_NUMBER_I-1:0]            s_axis_tready,
  input  logic [PE_NUMBER_I-1:0]            s_axis_tlast,
  input  logic [PE_NUMBER_I*ID_WIDTH-1:0]   s_axis_tid,
  input  logic [PE_NUMBER_I*DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [PE_NUMBER_I*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [ID_WIDTH-1:0]               m_axis_tid,
  output logic [DEST_WIDTH-1:0]             m_axis_tdest,
  output logic [USER_WIDTH-1:0]             m_axis_tuser,
  output logic                              err_unaligned_row
`ifdef LPA_COLLECT_ROW_COUNT_EN
  ,
  output logic [15:0]                       row_count
`endif
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned PW       = AW + 1;
  localparam int unsigned SEL_W    = $clog2(PE_NUMBER_I);
  localparam int unsigned OFS_USER = DATA_WIDTH;
  localparam int unsigned OFS_DEST = OFS_USER + USER_WIDTH;
  localparam int unsigned OFS_ID   = OFS_DEST + DEST_WIDTH;
  localparam int unsigned OFS_LAST = OFS_ID + ID_WIDTH;
  localparam int unsigned ENT_W    = OFS_LAST + 1;

  logic [ENT_W-1:0]       lane_head [PE_NUMBER_I];
  logic [PE_NUMBER_I-1:0] lane_empty;
  logic [PE_NUMBER_I-1:0] lane_full;
  logic [PE_NUMBER_I-1:0] lane_push;
  logic [PE_NUMBER_I-1:0] lane_pop;
  logic                   ready_en_q;
  logic                   load;
  logic                   sel_last;
  logic [ENT_W-1:0]       head;

  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic                   m_last_q, m_last_d;
  logic [ID_WIDTH-1:0]    m_id_q, m_id_d;
  logic [DEST_WIDTH-1:0]  m_dest_q, m_dest_d;
  logic [USER_WIDTH-1:0]  m_user_q, m_user_d;
  logic                   row_last_q, row_last_d;
  logic                   err_q, err_d;

  // Input ready stays low during reset and for the release edge itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en_q <= 1'b0;
    else      ready_en_q <= 1'b1;
  end

  assign s_axis_tready = ~lane_full & {PE_NUMBER_I{ready_en_q}};
  assign lane_push     = s_axis_tvalid & s_axis_tready;

  // Per-lane FIFO with an extra wrap bit on the pointers to tell full from empty.
  for (genvar g = 0; g < PE_NUMBER_I; g++) begin : g_lane
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [ENT_W-1:0] entry_in;

    assign entry_in = {s_axis_tlast[g],
                       s_axis_tid[g*ID_WIDTH +: ID_WIDTH],
                       s_axis_tdest[g*DEST_WIDTH +: DEST_WIDTH],
                       s_axis_tuser[g*USER_WIDTH +: USER_WIDTH],
                       s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH]};

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (lane_push[g]) wr_q <= wr_q + PW'(1);
        if (lane_pop[g])  rd_q <= rd_q + PW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (lane_push[g]) mem_q[wr_q[AW-1:0]] <= entry_in;
    end

    assign lane_empty[g] = (wr_q == rd_q);
    assign lane_full[g]  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign lane_head[g]  = mem_q[rd_q[AW-1:0]];
    assign lane_pop[g]   = load && (sel_q == SEL_W'(g));
  end

  assign head     = lane_head[sel_q];
  assign sel_last = (sel_q == SEL_W'(PE_NUMBER_I - 1));
  assign load     = (!m_valid_q || m_axis_tready) && !lane_empty[sel_q];

  // Output register and strict column sequencing; a stalled lane blocks the whole row.
  always_comb begin
    sel_d      = sel_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_id_d     = m_id_q;
    m_dest_d   = m_dest_q;
    m_user_d   = m_user_q;
    row_last_d = row_last_q;
    err_d      = err_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = head[DATA_WIDTH-1:0];
      m_last_d  = head[OFS_LAST] & sel_last;
      m_id_d    = (ID_ENABLE   != 0) ? head[OFS_ID   +: ID_WIDTH]   : '0;
      m_dest_d  = (DEST_ENABLE != 0) ? head[OFS_DEST +: DEST_WIDTH] : '0;
      m_user_d  = (USER_ENABLE != 0) ? head[OFS_USER +: USER_WIDTH] : '0;
      sel_d     = sel_last ? '0 : sel_q + SEL_W'(1);
      if (sel_q == '0)                       row_last_d = head[OFS_LAST];
      else if (head[OFS_LAST] != row_last_q) err_d      = 1'b1;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q      <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      m_id_q     <= '0;
      m_dest_q   <= '0;
      m_user_q   <= '0;
      row_last_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      m_id_q     <= m_id_d;
      m_dest_q   <= m_dest_d;
      m_user_q   <= m_user_d;
      row_last_q <= row_last_d;
      err_q      <= err_d;
    end
  end

  assign m_axis_tvalid     = m_valid_q;
  assign m_axis_tdata      = m_data_q;
  assign m_axis_tlast      = m_last_q;
  assign m_axis_tid        = m_id_q;
  assign m_axis_tdest      = m_dest_q;
  assign m_axis_tuser      = m_user_q;
  assign err_unaligned_row = err_q;

`ifdef LPA_COLLECT_ROW_COUNT_EN
  logic        lastcol_q;
  logic [15:0] row_count_q;

  // Counts rows on the output handshake of their final column, wrapping naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastcol_q   <= 1'b0;
      row_count_q <= '0;
    end else begin
      if (load) lastcol_q <= sel_last;
      if (m_valid_q && m_axis_tready && lastcol_q) row_count_q <= row_count_q + 16'd1;
    end
  end

  assign row_count = row_count_q;
`endif

endmodule

// File: tb/tb_lpa_result_collector.sv
// Directed bench for lpa_result_collector: per-lane beat queues drive the inputs, output handshakes are captured.
module tb_lpa_result_collector;

  localparam int unsigned NL = 4;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic          err;
    logic [31:0]   cyc;
  } cap_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NL*DW-1:0] s_tdata;
  logic [NL-1:0]    s_tvalid;
  logic [NL-1:0]    s_tready;
  logic [NL-1:0]    s_tlast;
  logic [NL-1:0]    s_tid;
  logic [NL-1:0]    s_tdest;
  logic [NL-1:0]    s_tuser;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [0:0]       m_tid;
  logic [0:0]       m_tdest;
  logic [0:0]       m_tuser;
  logic             err;
`ifdef LPA_COLLECT_ROW_COUNT_EN
  logic [15:0]      row_count;
`endif

  beat_t lane_q [NL][$];
  cap_t  caps [$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  lpa_result_collector dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_tdata),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .s_axis_tlast      (s_tlast),
    .s_axis_tid        (s_tid),
    .s_axis_tdest      (s_tdest),
    .s_axis_tuser      (s_tuser),
    .m_axis_tdata      (m_tdata),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tready     (m_tready),
    .m_axis_tlast      (m_tlast),
    .m_axis_tid        (m_tid),
    .m_axis_tdest      (m_tdest),
    .m_axis_tuser      (m_tuser),
    .err_unaligned_row (err)
`ifdef LPA_COLLECT_ROW_COUNT_EN
    ,
    .row_count         (row_count)
`endif
  );

  task automatic push_beat(input int lane, input logic [DW-1:0] d, input logic last);
    beat_t b;
    b.v = 1'b1; b.d = d; b.last = last;
    lane_q[lane].push_back(b);
  endtask

  task automatic push_bubble(input int lane);
    beat_t b;
    b.v = 1'b0; b.d = '0; b.last = 1'b0;
    lane_q[lane].push_back(b);
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < NL; i++) lane_q[i].delete();
  endtask

  // One clock: present queue heads, observe at negedge, retire accepted beats after the edge.
  task automatic step();
    logic [NL-1:0] cons;
    cap_t c;
    for (int i = 0; i < NL; i++) begin
      if (lane_q[i].size() > 0) begin
        s_tvalid[i]         = lane_q[i][0].v;
        s_tdata[i*DW +: DW] = lane_q[i][0].d;
        s_tlast[i]          = lane_q[i][0].last;
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i]          = 1'b0;
      end
    end
    @(negedge clk);
    for (int i = 0; i < NL; i++)
      cons[i] = (lane_q[i].size() > 0) && (!lane_q[i][0].v || s_tready[i]);
    if (m_tvalid && m_tready) begin
      c.d = m_tdata; c.last = m_tlast; c.err = err; c.cyc = 32'(cyc);
      caps.push_back(c);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++)
      if (cons[i]) void'(lane_q[i].pop_front());
    cyc++;
  endtask

  task automatic run_until(input int n, input int budget);
    int k;
    k = 0;
    while (caps.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset_state();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
    n_tests++; if (s_tready !== 4'h0) begin n_fail++; $display("FAIL rst_tready: got %h want 0", s_tready); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_tests++; if (m_tdata !== 16'h0) begin n_fail++; $display("FAIL rst_tdata: got %h want 0", m_tdata); end
    n_tests++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b want 0", m_tlast); end
    rst = 1'b1;
    step();
    n_tests++; if (s_tready !== 4'hF) begin n_fail++; $display("FAIL rel_tready: got %h want f", s_tready); end
  endtask

  task automatic test_skewed_row();
    int base;
    caps.delete();
    m_tready = 1'b1;
    base = cyc;
    for (int i = 0; i < NL; i++) begin
      for (int b = 0; b < i; b++) push_bubble(i);
      push_beat(i, 16'(16'h0011 * (i + 1)), 1'b0);
    end
    run_until(4, 20);
    n_tests++; if (caps.size() !== 4) begin n_fail++; $display("FAIL skew_count: got %0d want 4", caps.size()); end
    for (int k = 0; k < 4 && k < caps.size(); k++) begin
      n_tests++;
      if (caps[k].d !== 16'(16'h0011 * (k + 1))) begin
        n_fail++; $display("FAIL skew_data[%0d]: got %h want %h", k, caps[k].d, 16'(16'h0011 * (k + 1)));
      end
      n_tests++;
      if (caps[k].cyc !== 32'(base + 2 + k)) begin
        n_fail++; $display("FAIL skew_cycle[%0d]: got %0d want %0d", k, caps[k].cyc, base + 2 + k);
      end
    end
  endtask

  task automatic test_backpressure();
    caps.delete();
    m_tready = 1'b0;
    for (int i = 0; i < NL; i++) begin
      for (int b = 0; b < i; b++) push_bubble(i);
      for (int r = 0; r < 2; r++) push_beat(i, 16'(16'h0100 + r * 16 + i), 1'b0);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      if (k >= 2) begin
        n_tests++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid@%0d: got %b want 1", k, m_tvalid); end
        n_tests++; if (m_tdata !== 16'h0100) begin n_fail++; $display("FAIL bp_hold_data@%0d: got %h want 0100", k, m_tdata); end
      end
    end
    n_tests++; if (caps.size() !== 0) begin n_fail++; $display("FAIL bp_no_handshake: got %0d want 0", caps.size()); end
    m_tready = 1'b1;
    run_until(8, 30);
    n_tests++; if (caps.size() !== 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", caps.size()); end
    for (int k = 0; k < 8 && k < caps.size(); k++) begin
      n_tests++;
      if (caps[k].d !== 16'(16'h0100 + (k / 4) * 16 + (k % 4))) begin
        n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", k, caps[k].d, 16'(16'h0100 + (k / 4) * 16 + (k % 4)));
      end
    end
  endtask

  task automatic test_packet_end();
    caps.delete();
    m_tready = 1'b1;
    for (int i = 0; i < NL; i++) begin
      for (int b = 0; b < i; b++) push_bubble(i);
      for (int r = 0; r < 3; r++) push_beat(i, 16'(16'h0200 + r * 16 + i), r == 2);
    end
    step(); step(); step();
    n_tests++; if ({m_tid, m_tdest, m_tuser} !== 3'b000) begin n_fail++; $display("FAIL pe_sideband: got %b want 000", {m_tid, m_tdest, m_tuser}); end
    run_until(12, 30);
    n_tests++; if (caps.size() !== 12) begin n_fail++; $display("FAIL pe_count: got %0d want 12", caps.size()); end
    for (int k = 0; k < 12 && k < caps.size(); k++) begin
      n_tests++;
      if (caps[k].last !== (k == 11)) begin
        n_fail++; $display("FAIL pe_tlast[%0d]: got %b want %b", k, caps[k].last, k == 11);
      end
      n_tests++;
      if (caps[k].d !== 16'(16'h0200 + (k / 4) * 16 + (k % 4))) begin
        n_fail++; $display("FAIL pe_data[%0d]: got %h want %h", k, caps[k].d, 16'(16'h0200 + (k / 4) * 16 + (k % 4)));
      end
    end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL pe_err: got %b want 0", err); end
  endtask

  task automatic test_misaligned();
    caps.delete();
    m_tready = 1'b1;
    for (int i = 0; i < NL; i++) begin
      for (int b = 0; b < i; b++) push_bubble(i);
      for (int r = 0; r < 3; r++) push_beat(i, 16'(16'h0300 + r * 16 + i), (r == 1) && (i == 2));
    end
    run_until(12, 30);
    n_tests++; if (caps.size() !== 12) begin n_fail++; $display("FAIL mis_count: got %0d want 12", caps.size()); end
    for (int k = 0; k < 12 && k < caps.size(); k++) begin
      n_tests++;
      if (caps[k].err !== (k >= 6)) begin
        n_fail++; $display("FAIL mis_err[%0d]: got %b want %b", k, caps[k].err, k >= 6);
      end
      n_tests++;
      if (caps[k].last !== 1'b0) begin
        n_fail++; $display("FAIL mis_tlast[%0d]: got %b want 0", k, caps[k].last);
      end
    end
    repeat (3) step();
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL mis_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset();
    caps.delete();
    m_tready = 1'b0;
    for (int i = 0; i < NL; i++)
      for (int r = 0; r < 2; r++) push_beat(i, 16'(16'h0B00 + r * 16 + i), 1'b0);
    repeat (4) step();
    n_tests++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL mr_pre_valid: got %b want 1", m_tvalid); end
    rst = 1'b0;
    #1;
    n_tests++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mr_tvalid: got %b want 0", m_tvalid); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL mr_err: got %b want 0", err); end
    n_tests++; if (s_tready !== 4'h0) begin n_fail++; $display("FAIL mr_tready: got %h want 0", s_tready); end
    n_tests++; if (m_tdata !== 16'h0) begin n_fail++; $display("FAIL mr_tdata: got %h want 0", m_tdata); end
    clear_lanes();
    repeat (2) step();
    rst = 1'b1;
    step();
    n_tests++; if (s_tready !== 4'hF) begin n_fail++; $display("FAIL mr_rel_tready: got %h want f", s_tready); end
    m_tready = 1'b1;
    repeat (10) step();
    n_tests++; if (caps.size() !== 0) begin n_fail++; $display("FAIL mr_stale: got %0d beats want 0", caps.size()); end
    n_tests++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mr_idle_valid: got %b want 0", m_tvalid); end
`ifdef LPA_COLLECT_ROW_COUNT_EN
    n_tests++; if (row_count !== 16'd0) begin n_fail++; $display("FAIL mr_row_count: got %0d want 0", row_count); end
`endif
  endtask

  task automatic test_full_and_count();
    caps.delete();
    m_tready = 1'b0;
    for (int r = 0; r < 6; r++) push_beat(0, 16'(16'hA000 + r * 16), 1'b0);
    repeat (8) step();
    n_tests++; if (lane_q[0].size() !== 1) begin n_fail++; $display("FAIL full_accepted: got %0d left want 1", lane_q[0].size()); end
    n_tests++; if (s_tready !== 4'b1110) begin n_fail++; $display("FAIL full_tready: got %b want 1110", s_tready); end
    n_tests++; if (m_tdata !== 16'hA000) begin n_fail++; $display("FAIL full_head: got %h want a000", m_tdata); end
    lane_q[0].delete();
    for (int i = 1; i < NL; i++)
      for (int r = 0; r < 5; r++) push_beat(i, 16'(16'hA000 + r * 16 + i), 1'b0);
    m_tready = 1'b1;
    run_until(20, 60);
    n_tests++; if (caps.size() !== 20) begin n_fail++; $display("FAIL cnt_count: got %0d want 20", caps.size()); end
    for (int k = 0; k < 20 && k < caps.size(); k++) begin
      n_tests++;
      if (caps[k].d !== 16'(16'hA000 + (k / 4) * 16 + (k % 4))) begin
        n_fail++; $display("FAIL cnt_data[%0d]: got %h want %h", k, caps[k].d, 16'(16'hA000 + (k / 4) * 16 + (k % 4)));
      end
    end
    step();
    n_tests++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL cnt_drained: got %b want 0", m_tvalid); end
`ifdef LPA_COLLECT_ROW_COUNT_EN
    n_tests++; if (row_count !== 16'd5) begin n_fail++; $display("FAIL row_count: got %0d want 5", row_count); end
`endif
  endtask

  initial begin
    rst      = 1'b0;
    m_tready = 1'b0;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tid    = '0;
    s_tdest  = '0;
    s_tuser  = '0;
    test_reset_state();
    test_skewed_row();
    test_backpressure();
    test_packet_end();
    test_misaligned();
    test_reset();
    test_full_and_count();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
